xeng_par_pack: RTL

//  Input stage directly upstream of xeng_preproc. Accepts one dual-pol complex sample per valid cycle and packs
//  P_FACTOR consecutive samples into the parallel bus xeng_preproc consumes. Aligns word boundaries to sync.

---
 rtl/xeng_par_pack.sv | 136 +++++++++++++
 1 files changed

// File: rtl/xeng_par_pack.sv
// Packs P_FACTOR consecutive dual-pol samples into one xeng_preproc input word, sync-aligned with a frame flywheel.
// Optional XENG_PACK_ZERO_FILL_EN: on a misaligned sync, flush the partial word zero-filled instead of dropping it.
module xeng_par_pack #(
    parameter int SERIAL_ACC_LEN_BITS = 7,
    parameter int P_FACTOR_BITS       = 2,
    parameter int BITWIDTH            = 4
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          sync_in,
    input  logic                                          din_valid,
    input  logic [4*BITWIDTH-1:0]                         din,
    output logic [2*BITWIDTH*2*(1<<P_FACTOR_BITS)-1:0]    dout,
    output logic                                          dout_valid,
    output logic                                          sync_out,
    output logic                                          frame_err
);

    localparam int P_FACTOR = 1 << P_FACTOR_BITS;
    localparam int CW       = 2 * BITWIDTH;
    localparam int DW       = CW * 2 * P_FACTOR;
    localparam int SW       = (P_FACTOR_BITS > 0) ? P_FACTOR_BITS : 1;
    localparam int WW       = (SERIAL_ACC_LEN_BITS > 0) ? SERIAL_ACC_LEN_BITS : 1;
    localparam logic [SW-1:0] LAST_SLOT = SW'(P_FACTOR - 1);
    localparam logic [WW-1:0] LAST_WORD = WW'((1 << SERIAL_ACC_LEN_BITS) - 1);

    typedef enum logic {WAIT_SYNC, RUN} state_t;

    state_t          state_reg, state_next;
    logic [SW-1:0]   slot_cnt_reg, slot_cnt_next;
    logic [WW-1:0]   word_cnt_reg, word_cnt_next;
    logic            sync_pend_reg, sync_pend_next;
    logic [DW-1:0]   word_buf_reg, word_buf_next;
    logic [DW-1:0]   dout_reg, dout_next;
    logic            dout_valid_reg, dout_valid_next;
    logic            sync_out_reg, sync_out_next;
    logic            frame_err_reg, frame_err_next;

    logic            eff_sync;
    logic            accept;
    logic            misaligned;
    logic [SW-1:0]   wr_slot;
    logic [WW-1:0]   wr_word;
    logic [WW-1:0]   word_inc;
    logic [DW-1:0]   base_word;
    logic [DW-1:0]   fill_word;

    // A sync seen on an idle cycle rides on the next valid sample.
    assign eff_sync   = din_valid & (sync_in | sync_pend_reg);
    assign accept     = din_valid & ((state_reg == RUN) | eff_sync);
    assign misaligned = eff_sync & (state_reg == RUN)
                        & ((slot_cnt_reg != '0) | (word_cnt_reg != '0));
    assign wr_slot    = eff_sync ? '0 : slot_cnt_reg;
    assign wr_word    = eff_sync ? '0 : word_cnt_reg;
    assign word_inc   = (wr_word == LAST_WORD) ? '0 : wr_word + WW'(1);

    // Starting a new word clears the buffer so unfilled slots always read as zero.
    assign base_word  = (wr_slot == '0) ? '0 : word_buf_reg;

    generate
        for (genvar gi = 0; gi < P_FACTOR; gi++) begin : g_slot
            logic slot_sel;
            assign slot_sel = (wr_slot == SW'(gi));
            assign fill_word[gi*CW +: CW] =
                slot_sel ? din[CW-1:0] : base_word[gi*CW +: CW];
            assign fill_word[(P_FACTOR+gi)*CW +: CW] =
                slot_sel ? din[2*CW-1:CW] : base_word[(P_FACTOR+gi)*CW +: CW];
        end
    endgenerate

    always_comb begin
        state_next      = state_reg;
        slot_cnt_next   = slot_cnt_reg;
        word_cnt_next   = word_cnt_reg;
        word_buf_next   = word_buf_reg;
        dout_next       = dout_reg;
        dout_valid_next = 1'b0;
        sync_out_next   = 1'b0;
        frame_err_next  = misaligned;
        sync_pend_next  = din_valid ? 1'b0 : (sync_pend_reg | sync_in);

        if (accept) begin
            state_next    = RUN;
            word_buf_next = fill_word;
            if (wr_slot == LAST_SLOT) begin
                dout_next       = fill_word;
                dout_valid_next = 1'b1;
                sync_out_next   = (wr_word == '0);
                slot_cnt_next   = '0;
                word_cnt_next   = word_inc;
            end else begin
                slot_cnt_next   = wr_slot + SW'(1);
                word_cnt_next   = wr_word;
            end
        end

`ifdef XENG_PACK_ZERO_FILL_EN
        // Flush the interrupted word; it can never coincide with a completion above.
        if (misaligned && (slot_cnt_reg != '0)) begin
            dout_next       = word_buf_reg;
            dout_valid_next = 1'b1;
            sync_out_next   = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= WAIT_SYNC;
            slot_cnt_reg   <= '0;
            word_cnt_reg   <= '0;
            sync_pend_reg  <= 1'b0;
            word_buf_reg   <= '0;
            dout_reg       <= '0;
            dout_valid_reg <= 1'b0;
            sync_out_reg   <= 1'b0;
            frame_err_reg  <= 1'b0;
        end else begin
            state_reg      <= state_next;
            slot_cnt_reg   <= slot_cnt_next;
            word_cnt_reg   <= word_cnt_next;
            sync_pend_reg  <= sync_pend_next;
            word_buf_reg   <= word_buf_next;
            dout_reg       <= dout_next;
            dout_valid_reg <= dout_valid_next;
            sync_out_reg   <= sync_out_next;
            frame_err_reg  <= frame_err_next;
        end
    end

    assign dout       = dout_reg;
    assign dout_valid = dout_valid_reg;
    assign sync_out   = sync_out_reg;
    assign frame_err  = frame_err_reg;

endmodule
